mcu_router: RTL and testbench

MCU_ROUTER -- requirements
Module: mcu_router

---
 rtl/mcu_router_pkg.sv | 23 ++
 rtl/mcu_irq_latch.sv | 44 ++++
 rtl/mcu_router.sv | 135 +++++++++++++
 tb/tb_mcu_router.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mcu_router_pkg.sv
// Shared types and constants for the MCU byte router and its interrupt latch.
package mcu_router_pkg;

  localparam int NTGT = 4;
  localparam logic [7:0] LOCAL_ID = 8'h0F;

  localparam logic [1:0] TGT_SYS = 2'd0;
  localparam logic [1:0] TGT_HID = 2'd1;
  localparam logic [1:0] TGT_OSD = 2'd2;
  localparam logic [1:0] TGT_SDC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FORWARD = 2'd1,
    ST_LOCAL   = 2'd2,
    ST_DISCARD = 2'd3
  } state_e;

  function automatic logic [NTGT-1:0] tgt_onehot(input logic [1:0] sel);
    return NTGT'(1) << sel;
  endfunction

endpackage

// File: rtl/mcu_irq_latch.sv
// Per-target interrupt latch: rising-edge detect, sticky pending bits with
// MCU acknowledge, and a registered active-low aggregate interrupt.
module mcu_irq_latch
  import mcu_router_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [NTGT-1:0] tgt_int,
  input  logic            ack_valid,
  input  logic [NTGT-1:0] ack_mask,
  output logic [NTGT-1:0] pending,
  output logic            int_out_n
);

  logic [NTGT-1:0] int_prev_q;
  logic [NTGT-1:0] pending_q, pending_d;
  logic [NTGT-1:0] rise;
  logic            int_out_n_q;

  assign rise = tgt_int & ~int_prev_q;

  // A new edge in the same cycle as an acknowledge must not be lost.
  always_comb begin
    pending_d = pending_q;
    if (ack_valid) pending_d = pending_d & ~ack_mask;
    pending_d = pending_d | rise;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      int_prev_q  <= '0;
      pending_q   <= '0;
      int_out_n_q <= 1'b1;
    end else begin
      int_prev_q  <= tgt_int;
      pending_q   <= pending_d;
      int_out_n_q <= ~|pending_q;
    end
  end

  assign pending   = pending_q;
  assign int_out_n = int_out_n_q;

endmodule

// File: rtl/mcu_router.sv
// MCU-to-target byte router with a local interrupt-acknowledge endpoint.
// Optional frame watchdog enabled by defining MCU_ROUTER_TIMEOUT_EN.
module mcu_router
  import mcu_router_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mcu_strobe,
  input  logic        mcu_start,
  input  logic [7:0]  mcu_data,
  output logic [7:0]  mcu_dout,
  output logic [3:0]  tgt_strobe,
  output logic        tgt_start,
  output logic [7:0]  tgt_data,
  input  logic [31:0] tgt_dout,
  input  logic [3:0]  tgt_int,
  output logic        int_out_n,
  output logic        frame_timeout
);

  localparam logic [1:0] S_IDLE    = ST_IDLE;
  localparam logic [1:0] S_FORWARD = ST_FORWARD;
  localparam logic [1:0] S_LOCAL   = ST_LOCAL;
  localparam logic [1:0] S_DISCARD = ST_DISCARD;

  logic [1:0]      state_q, state_d;
  logic [1:0]      sel_q, sel_d;
  logic            first_q, first_d;
  logic [7:0]      mcu_dout_q, mcu_dout_d;
  logic [NTGT-1:0] tgt_strobe_q;
  logic            tgt_start_q;
  logic [7:0]      tgt_data_q;
  logic            payload, fwd_fire, ack_fire, timeout_fire;
  logic [NTGT-1:0] pending;

  assign payload  = mcu_strobe & ~mcu_start;
  assign fwd_fire = payload && (state_q == S_FORWARD);
  assign ack_fire = payload && (state_q == S_LOCAL) && first_q;

`ifdef MCU_ROUTER_TIMEOUT_EN
  logic [15:0] wd_cnt_q;
  logic [15:0] wd_inc;
  logic        timeout_q;

  assign wd_inc = wd_cnt_q + 16'd1;
  // Any strobe restarts the idle count, so a strobe always beats the abort.
  assign timeout_fire = !mcu_strobe && (state_q != S_IDLE) && (wd_inc == TIMEOUT_CYCLES);

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_q  <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_fire;
      if (mcu_strobe || (state_q == S_IDLE) || timeout_fire) wd_cnt_q <= 16'd0;
      else wd_cnt_q <= wd_inc;
    end
  end

  assign frame_timeout = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_fire  = 1'b0;
  assign frame_timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    first_d = first_q;
    if (mcu_strobe && mcu_start) begin
      first_d = 1'b1;
      if (mcu_data < 8'd4) begin
        state_d = S_FORWARD;
        sel_d   = mcu_data[1:0];
      end else if (mcu_data == LOCAL_ID) begin
        state_d = S_LOCAL;
      end else begin
        state_d = S_DISCARD;
      end
    end else if (fwd_fire || (payload && state_q == S_LOCAL)) begin
      first_d = 1'b0;
    end else if (timeout_fire) begin
      state_d = S_IDLE;
      first_d = 1'b0;
    end
  end

  always_comb begin
    case (state_q)
      S_FORWARD: mcu_dout_d = tgt_dout[8*sel_q +: 8];
      S_LOCAL:   mcu_dout_d = {4'h0, pending};
      default:   mcu_dout_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      sel_q        <= 2'd0;
      first_q      <= 1'b0;
      mcu_dout_q   <= 8'h00;
      tgt_strobe_q <= '0;
      tgt_start_q  <= 1'b0;
      tgt_data_q   <= 8'h00;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      first_q      <= first_d;
      mcu_dout_q   <= mcu_dout_d;
      tgt_strobe_q <= fwd_fire ? tgt_onehot(sel_q) : '0;
      tgt_start_q  <= fwd_fire && first_q;
      if (fwd_fire) tgt_data_q <= mcu_data;
    end
  end

  mcu_irq_latch u_irq (
    .clk       (clk),
    .reset     (reset),
    .tgt_int   (tgt_int),
    .ack_valid (ack_fire),
    .ack_mask  (mcu_data[3:0]),
    .pending   (pending),
    .int_out_n (int_out_n)
  );

  assign mcu_dout   = mcu_dout_q;
  assign tgt_strobe = tgt_strobe_q;
  assign tgt_start  = tgt_start_q;
  assign tgt_data   = tgt_data_q;

endmodule

// File: tb/tb_mcu_router.sv
// Directed plus randomized bench for mcu_router against a frame-level reference model.
module tb_mcu_router;

  localparam logic [15:0] TO = 16'd100;

  logic        clk = 1'b0;
  logic        reset;
  logic        mcu_strobe, mcu_start;
  logic [7:0]  mcu_data, mcu_dout;
  logic [3:0]  tgt_strobe;
  logic        tgt_start;
  logic [7:0]  tgt_data;
  logic [31:0] tgt_dout;
  logic [3:0]  tgt_int;
  logic        int_out_n, frame_timeout;

  int n_checks = 0;
  int n_pass   = 0;
  int step_no  = 0;

  // Frame-level model: which kind of frame is open, who is addressed,
  // whether the first payload byte is still to come, and the pending set.
  localparam int M_IDLE = 0, M_FWD = 1, M_LOCAL = 2, M_DROP = 3;
  int         m_mode;
  int         m_sel;
  bit         m_first;
  logic [3:0] m_pend, m_prev;
  int         m_cnt;

  logic [3:0] e_strobe;
  logic       e_start, e_intn, e_to;
  logic [7:0] e_data, e_dout;

  mcu_router #(.TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .mcu_strobe    (mcu_strobe),
    .mcu_start     (mcu_start),
    .mcu_data      (mcu_data),
    .mcu_dout      (mcu_dout),
    .tgt_strobe    (tgt_strobe),
    .tgt_start     (tgt_start),
    .tgt_data      (tgt_data),
    .tgt_dout      (tgt_dout),
    .tgt_int       (tgt_int),
    .int_out_n     (int_out_n),
    .frame_timeout (frame_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s step %0d: got %0h, expected %0h", tag, step_no, obs, exp);
  endtask

  task automatic check_all();
    chk("tgt_strobe", {28'd0, tgt_strobe}, {28'd0, e_strobe});
    chk("tgt_start", {31'd0, tgt_start}, {31'd0, e_start});
    chk("tgt_data", {24'd0, tgt_data}, {24'd0, e_data});
    chk("mcu_dout", {24'd0, mcu_dout}, {24'd0, e_dout});
    chk("int_out_n", {31'd0, int_out_n}, {31'd0, e_intn});
    chk("frame_timeout", {31'd0, frame_timeout}, {31'd0, e_to});
    $display("step %0d: strobe=%b start=%b data=%02h tgt_strobe=%b tgt_data=%02h mcu_dout=%02h int_out_n=%b",
             step_no, mcu_strobe, mcu_start, mcu_data, tgt_strobe, tgt_data, mcu_dout, int_out_n);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mcu_strobe = 1'b0;
    mcu_start = 1'b0;
    mcu_data = 8'h00;
    @(posedge clk);
    #1;
    m_mode = M_IDLE; m_sel = 0; m_first = 0; m_pend = 4'h0; m_prev = 4'h0; m_cnt = 0;
    e_strobe = 4'h0; e_start = 0; e_data = 8'h00; e_dout = 8'h00; e_intn = 1; e_to = 0;
    check_all();
    step_no++;
    reset = 1'b0;
  endtask

  task automatic step(input logic s, input logic st, input logic [7:0] d,
                      input logic [3:0] ti, input logic [31:0] td);
    logic       fwd, to_now;
    logic [3:0] ack;
    mcu_strobe = s; mcu_start = st; mcu_data = d; tgt_int = ti; tgt_dout = td;

    // Outputs that will be visible after this clock edge.
    e_dout   = (m_mode == M_FWD) ? 8'((td >> (8 * m_sel)) & 32'hFF) :
               (m_mode == M_LOCAL) ? {4'h0, m_pend} : 8'h00;
    e_intn   = (m_pend == 4'h0);
    fwd      = s && !st && (m_mode == M_FWD);
    e_strobe = fwd ? 4'(1 << m_sel) : 4'h0;
    e_start  = fwd && m_first;
    if (fwd) e_data = d;

    ack    = (s && !st && m_mode == M_LOCAL && m_first) ? d[3:0] : 4'h0;
    m_pend = (m_pend & ~ack) | (ti & ~m_prev);
    m_prev = ti;

    to_now = 0;
`ifdef MCU_ROUTER_TIMEOUT_EN
    if (s || m_mode == M_IDLE) m_cnt = 0;
    else begin
      m_cnt++;
      if (m_cnt == int'(TO)) begin
        to_now = 1;
        m_cnt = 0;
      end
    end
`endif
    e_to = to_now;

    if (s && st) begin
      m_first = 1;
      if (d < 4) begin m_mode = M_FWD; m_sel = int'(d); end
      else if (d == 8'h0F) m_mode = M_LOCAL;
      else m_mode = M_DROP;
    end else if (s && (m_mode == M_FWD || m_mode == M_LOCAL)) begin
      m_first = 0;
    end else if (to_now) begin
      m_mode = M_IDLE;
      m_first = 0;
    end

    @(posedge clk);
    #1;
    check_all();
    step_no++;
  endtask

  logic [3:0] ti_r;
  logic [7:0] d_r;

  initial begin
    tgt_int = 4'h0;
    tgt_dout = 32'h0;
    do_reset();

    // Forward to target 0: first payload carries tgt_start, dout follows target 0.
    step(1, 1, 8'h00, 4'h0, $urandom());
    step(1, 0, 8'h00, 4'h0, $urandom());
    step(1, 0, 8'hAA, 4'h0, $urandom());
    step(1, 0, 8'h55, 4'h0, $urandom());
    step(0, 0, 8'h00, 4'h0, $urandom());
    step(0, 0, 8'h00, 4'h0, $urandom());

    // Back-to-back frames to targets 2 and 1.
    step(1, 1, 8'h02, 4'h0, $urandom());
    step(1, 0, 8'h11, 4'h0, $urandom());
    step(1, 1, 8'h01, 4'h0, $urandom());
    step(1, 0, 8'h22, 4'h0, $urandom());
    step(0, 0, 8'h00, 4'h0, $urandom());

    // Unknown id: discarded.
    step(1, 1, 8'h07, 4'h0, $urandom());
    for (int i = 0; i < 3; i++) step(1, 0, 8'($urandom()), 4'h0, $urandom());
    step(0, 0, 8'h00, 4'h0, $urandom());

    // Interrupts, local ack, and set-beats-clear.
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 4'b0101, $urandom());
    step(1, 1, 8'h0F, 4'b0101, $urandom());
    step(1, 0, 8'h01, 4'b0101, $urandom());
    step(0, 0, 8'h00, 4'b0101, $urandom());
    step(0, 0, 8'h00, 4'b0101, $urandom());
    step(0, 0, 8'h00, 4'b0001, $urandom());
    step(1, 1, 8'h0F, 4'b0001, $urandom());
    step(1, 0, 8'h04, 4'b0101, $urandom());
    step(0, 0, 8'h00, 4'b0101, $urandom());
    step(0, 0, 8'h00, 4'b0101, $urandom());

    // Idle frame long enough for the watchdog (when built in).
    step(1, 1, 8'h03, 4'h0, $urandom());
    for (int i = 0; i < 101; i++) step(0, 0, 8'h00, 4'h0, $urandom());
    step(1, 0, 8'h77, 4'h0, $urandom());
    step(0, 0, 8'h00, 4'h0, $urandom());

    // Reset between payload bytes.
    step(1, 1, 8'h01, 4'h0, $urandom());
    step(1, 0, 8'h33, 4'h0, $urandom());
    do_reset();
    step(1, 0, 8'h44, 4'h0, $urandom());
    step(0, 0, 8'h00, 4'h0, $urandom());

    // Randomized traffic.
    ti_r = 4'h0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 79) == 0) do_reset();
      if ($urandom_range(0, 3) == 0) ti_r[$urandom_range(0, 3)] ^= 1'b1;
      case ($urandom_range(0, 3))
        0: d_r = 8'($urandom_range(0, 3));
        1: d_r = 8'h0F;
        default: d_r = 8'($urandom());
      endcase
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), d_r, ti_r, $urandom());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
